lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the ALU/register-file side of the core and the word-organised data RAM (one 32-bit word per index, synchronous read, registered RD, no byte enables).
- Translates RV32I byte, halfword and word loads and stores into RAM word accesses.
- Sub-word stores are performed as read-modify-write.
- Loads are sign-extended or zero-extended before being returned.

Parameters:
- ADDRESS_WIDTH, 32, width of byte address from ALU and of word index to RAM
- DATA_WIDTH, 32, data width; fixed at 32 (four byte lanes, little-endian)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  core presents a memory request
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  ADDRESS_WIDTH  byte address (ALU result)
- req_wdata  input  DATA_WIDTH  store data (rs2), low bytes used for B/H
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  DATA_WIDTH  extended load data (0 for stores/errors)
- resp_err  output  1  qualified by resp_valid: misaligned or illegal funct3
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDRESS_WIDTH  RAM word index = {2'b00, addr_q[ADDRESS_WIDTH-1:2]}
- mem_wd  output  DATA_WIDTH  RAM write data
- mem_rd  input  DATA_WIDTH  RAM read data, valid the cycle after mem_addr is presented

Behaviour:
- Reset, asynchronous: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_wd=0; captured request registers=0.
- States: IDLE, READ, MERGE, WRITE, RESP.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. At that edge addr_q, funct3_q, we_q and wdata_q are captured. req_ready=0 in every state except IDLE. Requests are never queued.
- Legality, decoded at accept:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Loads allow funct3 000/001/010/100/101. Stores allow only 000/001/010.
  - An illegal or misaligned request goes IDLE->RESP with resp_err=1 and resp_rdata=0. No RAM access is made (mem_we stays 0).
- IDLE transitions: legal load -> READ; legal SW -> WRITE; legal SB/SH -> READ.
- READ: mem_we=0 and mem_addr driven from addr_q. Always -> MERGE.
- MERGE: mem_rd holds the word.
  - Load: select the lane by addr_q[1:0] (byte) or addr_q[1] (half), extend it per funct3_q, register into resp_rdata; -> RESP.
  - Store: replace the addressed lane(s) of mem_rd with wdata_q[7:0] or wdata_q[15:0], hold the result in merge buffer; -> WRITE.
- WRITE: mem_we=1 for exactly one cycle. mem_wd = wdata_q (SW) or the merge buffer (SB/SH). -> RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_err and resp_rdata are valid this cycle. -> IDLE. There is no response backpressure.
- mem_we and mem_addr are combinational from state and addr_q. mem_we=1 only in WRITE. mem_addr is held for the whole transaction.
- Latency, in cycles after the accept edge until resp_valid:
  - Load: 3
  - SW: 2
  - SB/SH: 4
  - Error: 1
- Throughput: the next request may be accepted in the cycle after RESP (IDLE).
- Stores return resp_rdata=0.
- Address wrap: addr_q upper bits pass through unmodified. No bounds check.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_we drops asynchronously. A store aborted before WRITE leaves RAM unchanged. No resp_valid is produced for the aborted request.
- Input changes on req_* outside the accept edge have no effect.

Test Plan:
- RAM[1]=0x8070F0AA, LB addr 0x5 -> resp_valid 3 cycles after accept, resp_rdata=0xFFFFFFF0, resp_err=0; LBU addr 0x5 -> 0x000000F0.
- Same word, LH addr 0x6 -> 0xFFFF8070; LHU addr 0x6 -> 0x00008070; LW addr 0x4 -> 0x8070F0AA.
- SW addr 0x8 data 0xDEADBEEF -> mem_we high exactly once, 1 cycle after accept, mem_addr=2; resp_valid 2 cycles after accept; subsequent LW 0x8 -> 0xDEADBEEF.
- RAM[3]=0x11223344, SB addr 0xE data 0x000000AB -> read then write, RAM[3]=0x11AB3344; SH addr 0xC data 0xCAFE -> RAM[3]=0x11ABCAFE; resp_valid 4 cycles after accept.
- LW addr 0x2, SH addr 0x3, load funct3=011, store funct3=100 -> each resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0, mem_we never asserted.
- Assert rst during READ of an SB -> state IDLE, req_ready=1, no resp_valid, target RAM word unchanged; a new LW after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: RV32I B/H/W loads and stores onto a word-wide synchronous RAM.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module lsu_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [2:0]               r_funct3;
    logic                     r_we;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [DATA_WIDTH-1:0]    r_merge;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_f3_ok;
    logic                     w_misal;
    logic                     w_illegal;
    logic [DATA_WIDTH-1:0]    w_shift;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load;
    logic [DATA_WIDTH-1:0]    w_merge;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_f3_ok = 1'b0;
        unique case (req_funct3)
            F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_f3_ok = !req_we;
            default:          w_f3_ok = 1'b0;
        endcase
    end

    // Alignment depends only on the access size, i.e. funct3[1:0]
    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_illegal = !w_f3_ok || w_misal;

    assign w_shift = mem_rd >> {r_addr[1:0], 3'b000};
    assign w_half  = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        w_load = '0;
        unique case (r_funct3)
            F3_B:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_BU:   w_load = {24'h0, w_shift[7:0]};
            F3_H:    w_load = {{16{w_half[15]}}, w_half};
            F3_HU:   w_load = {16'h0, w_half};
            default: w_load = mem_rd;
        endcase
    end

    always_comb begin
        w_merge = mem_rd;
        if (r_funct3[1:0] == 2'b00) begin
            unique case (r_addr[1:0])
                2'b00:   w_merge[7:0]   = r_wdata[7:0];
                2'b01:   w_merge[15:8]  = r_wdata[7:0];
                2'b10:   w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_illegal) begin
                        w_next = S_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: w_next = S_MERGE;
            S_MERGE: w_next = r_we ? S_WRITE : S_RESP;
            S_WRITE: begin
                mem_we = 1'b1;
                mem_wd = (r_funct3 == F3_W) ? r_wdata : r_merge;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_merge  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                r_wdata  <= req_wdata;
                r_rdata  <= '0;
                r_err    <= w_illegal;
            end
            if (r_state == S_MERGE) begin
                if (r_we) begin
                    r_merge <= w_merge;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign mem_addr   = {2'b00, r_addr[ADDRESS_WIDTH-1:2]};
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
